// File: rtl/video_timing_pkg.sv
// Shared raster timing constants for the HDMI output path.
// Holds the 720p60 defaults, a 1080p60 set and the counter/coordinate widths.
package video_timing_pkg;

    localparam int COORD_W = 11;
    localparam int CNT_W   = 12;

    // 1280x720@60, 74.25 MHz pixel clock
    localparam int HD720_H_SYNC   = 40;
    localparam int HD720_H_BACK   = 220;
    localparam int HD720_H_ACTIVE = 1280;
    localparam int HD720_H_FRONT  = 110;
    localparam int HD720_V_SYNC   = 5;
    localparam int HD720_V_BACK   = 20;
    localparam int HD720_V_ACTIVE = 720;
    localparam int HD720_V_FRONT  = 5;

    // 1920x1080@60, 148.5 MHz pixel clock
    localparam int HD1080_H_SYNC   = 44;
    localparam int HD1080_H_BACK   = 148;
    localparam int HD1080_H_ACTIVE = 1920;
    localparam int HD1080_H_FRONT  = 88;
    localparam int HD1080_V_SYNC   = 5;
    localparam int HD1080_V_BACK   = 36;
    localparam int HD1080_V_ACTIVE = 1080;
    localparam int HD1080_V_FRONT  = 4;

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, pixel request decode and a single
// output register stage feeding the DVI transmitter.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   H_SYNC   = HD720_H_SYNC,
    parameter int   H_BACK   = HD720_H_BACK,
    parameter int   H_ACTIVE = HD720_H_ACTIVE,
    parameter int   H_FRONT  = HD720_H_FRONT,
    parameter int   V_SYNC   = HD720_V_SYNC,
    parameter int   V_BACK   = HD720_V_BACK,
    parameter int   V_ACTIVE = HD720_V_ACTIVE,
    parameter int   V_FRONT  = HD720_V_FRONT,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic [23:0] pixel_data,
    output logic        data_req,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        video_hsync,
    output logic        video_vsync,
    output logic        video_de,
    output logic [23:0] video_din,
    output logic        frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_START = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] H_ACT_END   = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_START = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] V_ACT_END   = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic             frame_start_q, frame_start_d;

    logic h_wrap;
    logic h_sync_seg, v_sync_seg;
    logic h_active, v_active;

    // v_cnt only moves on the h wrap, so both counters roll over together at frame end
    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_comb begin
        h_sync_seg = (h_cnt_q < H_SYNC_END);
        v_sync_seg = (v_cnt_q < V_SYNC_END);
        h_active   = (h_cnt_q >= H_ACT_START) && (h_cnt_q < H_ACT_END);
        v_active   = (v_cnt_q >= V_ACT_START) && (v_cnt_q < V_ACT_END);

        data_req   = h_active && v_active;
        pixel_xpos = data_req ? COORD_W'(h_cnt_q - H_ACT_START) : '0;
        pixel_ypos = data_req ? COORD_W'(v_cnt_q - V_ACT_START) : '0;

        hsync_d       = h_sync_seg ? SYNC_POL : ~SYNC_POL;
        vsync_d       = v_sync_seg ? SYNC_POL : ~SYNC_POL;
        de_d          = data_req;
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign video_hsync = hsync_q;
    assign video_vsync = vsync_q;
    assign video_de    = de_q;
    assign frame_start = frame_start_q;

    // pixel_data already trails data_req by a cycle, so it lines up with video_de unregistered
    assign video_din = de_q ? pixel_data : 24'h0;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: small-timing instances at both sync
// polarities plus a default 720p instance.
module tb_video_timing_gen;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic        reset_n;
    logic        reset_n_hd;
    logic [23:0] pixel_data;
    logic [23:0] pixel_data_neg;
    logic [23:0] pixel_data_hd;

    logic        data_req, video_hsync, video_vsync, video_de, frame_start;
    logic [10:0] pixel_xpos, pixel_ypos;
    logic [23:0] video_din;

    logic        neg_req, neg_hsync, neg_vsync, neg_de, neg_fs;
    logic [10:0] neg_xpos, neg_ypos;
    logic [23:0] neg_din;

    logic        hd_req, hd_hsync, hd_vsync, hd_de, hd_fs;
    logic [10:0] hd_xpos, hd_ypos;
    logic [23:0] hd_din;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic        de;
        logic [23:0] din;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    exp_t exp_q[$];

    video_timing_gen #(
        .H_SYNC(2), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
        .SYNC_POL(1'b1)
    ) u_dut (
        .pclk(pclk), .reset_n(reset_n), .pixel_data(pixel_data),
        .data_req(data_req), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
        .video_hsync(video_hsync), .video_vsync(video_vsync), .video_de(video_de),
        .video_din(video_din), .frame_start(frame_start)
    );

    video_timing_gen #(
        .H_SYNC(2), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
        .SYNC_POL(1'b0)
    ) u_dut_neg (
        .pclk(pclk), .reset_n(reset_n), .pixel_data(pixel_data_neg),
        .data_req(neg_req), .pixel_xpos(neg_xpos), .pixel_ypos(neg_ypos),
        .video_hsync(neg_hsync), .video_vsync(neg_vsync), .video_de(neg_de),
        .video_din(neg_din), .frame_start(neg_fs)
    );

    video_timing_gen u_dut_hd (
        .pclk(pclk), .reset_n(reset_n_hd), .pixel_data(pixel_data_hd),
        .data_req(hd_req), .pixel_xpos(hd_xpos), .pixel_ypos(hd_ypos),
        .video_hsync(hd_hsync), .video_vsync(hd_vsync), .video_de(hd_de),
        .video_din(hd_din), .frame_start(hd_fs)
    );

    // Frame source: registered lookup, answers each request one pclk later
    // and returns nonzero junk for idle cycles so the output blanking is visible.
    initial begin : pixel_source
        logic        req_s;
        logic [10:0] x_s, y_s;
        pixel_data = 24'h0;
        forever begin
            @(negedge pclk);
            req_s = data_req;
            x_s   = pixel_xpos;
            y_s   = pixel_ypos;
            @(posedge pclk);
            #1;
            pixel_data = (req_s === 1'b1) ? {y_s[7:0], x_s[7:0], 8'hA5}
                                          : (24'h5A0000 | 24'($urandom_range(1, 65535)));
        end
    end

    task automatic do_reset();
        @(negedge pclk);
        reset_n = 1'b0;
        repeat (2) @(negedge pclk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge pclk);
        reset_n = 1'b0;
        @(negedge pclk);
        n_checks++; if (video_hsync !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_hsync: got %b want 0", video_hsync); end
        n_checks++; if (video_vsync !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_vsync: got %b want 0", video_vsync); end
        n_checks++; if (video_de !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_de: got %b want 0", video_de); end
        n_checks++; if (video_din !== 24'h0) begin n_fails++; $display("[TB] FAIL reset_din: got %h want 000000", video_din); end
        n_checks++; if (data_req !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_req: got %b want 0", data_req); end
        n_checks++; if (frame_start !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_fs: got %b want 0", frame_start); end
        n_checks++; if (pixel_xpos !== 11'd0 || pixel_ypos !== 11'd0) begin n_fails++; $display("[TB] FAIL reset_coords: got %0d,%0d want 0,0", pixel_xpos, pixel_ypos); end
        reset_n = 1'b1;
        @(negedge pclk);
        n_checks++; if (frame_start !== 1'b1) begin n_fails++; $display("[TB] FAIL release_fs: got %b want 1", frame_start); end
        n_checks++; if (video_hsync !== 1'b1 || video_vsync !== 1'b1) begin n_fails++; $display("[TB] FAIL release_syncs: got %b%b want 11", video_hsync, video_vsync); end
        @(negedge pclk);
        n_checks++; if (frame_start !== 1'b0) begin n_fails++; $display("[TB] FAIL fs_one_cycle: got %b want 0", frame_start); end
    endtask

    task automatic test_timing_counts();
        int w, hs_hi, vs_hi, de_hi;
        int line, pos;
        logic exp_hs, exp_vs, exp_de;
        do_reset();
        w = 0;
        while (frame_start !== 1'b1 && w < 20) begin @(negedge pclk); w++; end
        n_checks++; if (frame_start !== 1'b1) begin n_fails++; $display("[TB] FAIL timing_fs_found: got %b want 1 within 20 cycles", frame_start); end
        hs_hi = 0; vs_hi = 0; de_hi = 0;
        for (int i = 0; i < 120; i++) begin
            line   = i / 15;
            pos    = i % 15;
            exp_hs = (pos < 2);
            exp_vs = (line < 1);
            exp_de = (line >= 3) && (line < 7) && (pos >= 5) && (pos < 13);
            n_checks++; if (video_hsync !== exp_hs) begin n_fails++; $display("[TB] FAIL timing_hsync@%0d: got %b want %b", i, video_hsync, exp_hs); end
            n_checks++; if (video_vsync !== exp_vs) begin n_fails++; $display("[TB] FAIL timing_vsync@%0d: got %b want %b", i, video_vsync, exp_vs); end
            n_checks++; if (video_de !== exp_de) begin n_fails++; $display("[TB] FAIL timing_de@%0d: got %b want %b", i, video_de, exp_de); end
            if (video_hsync === 1'b1) hs_hi++;
            if (video_vsync === 1'b1) vs_hi++;
            if (video_de === 1'b1) de_hi++;
            @(negedge pclk);
        end
        n_checks++; if (frame_start !== 1'b1) begin n_fails++; $display("[TB] FAIL frame_period_120: got fs=%b want 1", frame_start); end
        n_checks++; if (hs_hi != 16) begin n_fails++; $display("[TB] FAIL hsync_count: got %0d want 16", hs_hi); end
        n_checks++; if (vs_hi != 15) begin n_fails++; $display("[TB] FAIL vsync_count: got %0d want 15", vs_hi); end
        n_checks++; if (de_hi != 32) begin n_fails++; $display("[TB] FAIL de_count: got %0d want 32", de_hi); end
    endtask

    task automatic test_data_path();
        int th, tv, req_cnt;
        logic        exp_req, seen_first;
        logic [10:0] exp_x, exp_y, first_x, first_y, last_x, last_y;
        exp_t e, n;
        exp_q.delete();
        do_reset();
        th = 0; tv = 0; req_cnt = 0; seen_first = 1'b0;
        first_x = '1; first_y = '1; last_x = '1; last_y = '1;
        for (int c = 0; c < 240; c++) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++; if (video_de !== e.de) begin n_fails++; $display("[TB] FAIL dp_de@%0d: got %b want %b", c, video_de, e.de); end
                n_checks++; if (video_din !== e.din) begin n_fails++; $display("[TB] FAIL dp_din@%0d: got %h want %h", c, video_din, e.din); end
                n_checks++; if (video_hsync !== e.hs || video_vsync !== e.vs) begin n_fails++; $display("[TB] FAIL dp_syncs@%0d: got %b%b want %b%b", c, video_hsync, video_vsync, e.hs, e.vs); end
                n_checks++; if (frame_start !== e.fs) begin n_fails++; $display("[TB] FAIL dp_fs@%0d: got %b want %b", c, frame_start, e.fs); end
            end
            exp_req = (th >= 5) && (th < 13) && (tv >= 3) && (tv < 7);
            exp_x   = exp_req ? 11'(th - 5) : 11'd0;
            exp_y   = exp_req ? 11'(tv - 3) : 11'd0;
            n_checks++; if (data_req !== exp_req) begin n_fails++; $display("[TB] FAIL dp_req@%0d: got %b want %b", c, data_req, exp_req); end
            n_checks++; if (pixel_xpos !== exp_x || pixel_ypos !== exp_y) begin n_fails++; $display("[TB] FAIL dp_coords@%0d: got %0d,%0d want %0d,%0d", c, pixel_xpos, pixel_ypos, exp_x, exp_y); end
            if (c < 120 && data_req === 1'b1) begin
                req_cnt++;
                if (!seen_first) begin first_x = pixel_xpos; first_y = pixel_ypos; seen_first = 1'b1; end
                last_x = pixel_xpos; last_y = pixel_ypos;
            end
            n.de  = exp_req;
            n.din = exp_req ? {exp_y[7:0], exp_x[7:0], 8'hA5} : 24'h0;
            n.hs  = (th < 2);
            n.vs  = (tv < 1);
            n.fs  = (th == 0) && (tv == 0);
            exp_q.push_back(n);
            if (th == 14) begin
                th = 0;
                tv = (tv == 7) ? 0 : tv + 1;
            end else begin
                th++;
            end
            @(negedge pclk);
        end
        exp_q.delete();
        n_checks++; if (first_x !== 11'd0 || first_y !== 11'd0) begin n_fails++; $display("[TB] FAIL first_req_coords: got %0d,%0d want 0,0", first_x, first_y); end
        n_checks++; if (last_x !== 11'd7 || last_y !== 11'd3) begin n_fails++; $display("[TB] FAIL last_req_coords: got %0d,%0d want 7,3", last_x, last_y); end
        n_checks++; if (req_cnt != 32) begin n_fails++; $display("[TB] FAIL req_count: got %0d want 32", req_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int w, p;
        do_reset();
        w = 0;
        while (!(data_req === 1'b1 && pixel_ypos === 11'd2 && pixel_xpos === 11'd3) && w < 200) begin
            @(negedge pclk);
            w++;
        end
        n_checks++; if (data_req !== 1'b1 || pixel_ypos !== 11'd2) begin n_fails++; $display("[TB] FAIL midreset_target: got req=%b y=%0d want req=1 y=2", data_req, pixel_ypos); end
        n_checks++; if (video_de !== 1'b1) begin n_fails++; $display("[TB] FAIL midreset_de_before: got %b want 1", video_de); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (video_de !== 1'b0 || video_din !== 24'h0) begin n_fails++; $display("[TB] FAIL midreset_de_din: got %b/%h want 0/000000", video_de, video_din); end
        n_checks++; if (data_req !== 1'b0 || pixel_xpos !== 11'd0 || pixel_ypos !== 11'd0) begin n_fails++; $display("[TB] FAIL midreset_req: got %b %0d,%0d want 0 0,0", data_req, pixel_xpos, pixel_ypos); end
        n_checks++; if (video_hsync !== 1'b0 || video_vsync !== 1'b0 || frame_start !== 1'b0) begin n_fails++; $display("[TB] FAIL midreset_syncs: got %b%b%b want 000", video_hsync, video_vsync, frame_start); end
        repeat (2) @(negedge pclk);
        reset_n = 1'b1;
        w = 0;
        do begin @(negedge pclk); w++; end while (frame_start !== 1'b1 && w < 5);
        n_checks++; if (w != 1) begin n_fails++; $display("[TB] FAIL midreset_first_fs: got %0d cycles want 1", w); end
        p = 0;
        do begin @(negedge pclk); p++; end while (frame_start !== 1'b1 && p < 200);
        n_checks++; if (p != 120) begin n_fails++; $display("[TB] FAIL midreset_frame_period: got %0d want 120", p); end
    endtask

    task automatic test_polarity();
        int hs_lo, vs_lo;
        @(negedge pclk);
        reset_n = 1'b0;
        @(negedge pclk);
        n_checks++; if (neg_hsync !== 1'b1 || neg_vsync !== 1'b1) begin n_fails++; $display("[TB] FAIL neg_idle: got %b%b want 11", neg_hsync, neg_vsync); end
        reset_n = 1'b1;
        hs_lo = 0; vs_lo = 0;
        for (int i = 1; i <= 120; i++) begin
            @(negedge pclk);
            if (i == 1) begin
                n_checks++; if (neg_fs !== 1'b1 || neg_hsync !== 1'b0 || neg_vsync !== 1'b0) begin n_fails++; $display("[TB] FAIL neg_frame_start: got fs=%b hs=%b vs=%b want 1 0 0", neg_fs, neg_hsync, neg_vsync); end
            end
            if (neg_hsync === 1'b0) hs_lo++;
            if (neg_vsync === 1'b0) vs_lo++;
        end
        n_checks++; if (hs_lo != 16) begin n_fails++; $display("[TB] FAIL neg_hsync_low: got %0d want 16", hs_lo); end
        n_checks++; if (vs_lo != 15) begin n_fails++; $display("[TB] FAIL neg_vsync_low: got %0d want 15", vs_lo); end
    endtask

    task automatic test_default_720p();
        int rises, rise1, rise2, first_de, rises_before, run;
        logic prev_hs, done;
        @(negedge pclk);
        reset_n_hd = 1'b0;
        repeat (2) @(negedge pclk);
        reset_n_hd = 1'b1;
        prev_hs = hd_hsync;
        rises = 0; rise1 = -1; rise2 = -1; first_de = -1; rises_before = -1; run = 0; done = 1'b0;
        for (int i = 0; i < 45000 && !done; i++) begin
            if (i > 0) @(negedge pclk);
            if (hd_hsync === 1'b1 && prev_hs === 1'b0) begin
                rises++;
                if (rise1 < 0) rise1 = i;
                else if (rise2 < 0) rise2 = i;
            end
            prev_hs = hd_hsync;
            if (i == 1) begin
                n_checks++; if (hd_fs !== 1'b1) begin n_fails++; $display("[TB] FAIL hd_frame_start: got %b want 1", hd_fs); end
            end
            if (hd_de === 1'b1) begin
                if (first_de < 0) begin
                    first_de = i;
                    rises_before = rises;
                    n_checks++; if (hd_din !== 24'h123456) begin n_fails++; $display("[TB] FAIL hd_din: got %h want 123456", hd_din); end
                end
                run++;
            end else if (first_de >= 0) begin
                done = 1'b1;
            end
        end
        n_checks++; if (!done) begin n_fails++; $display("[TB] FAIL hd_timeout: got no complete active line within 45000 cycles"); end
        n_checks++; if (rise2 - rise1 != 1650) begin n_fails++; $display("[TB] FAIL hd_line_period: got %0d want 1650", rise2 - rise1); end
        n_checks++; if (first_de != 41511) begin n_fails++; $display("[TB] FAIL hd_first_de: got %0d want 41511", first_de); end
        n_checks++; if (rises_before != 26) begin n_fails++; $display("[TB] FAIL hd_lines_before_active: got %0d want 26", rises_before); end
        n_checks++; if (run != 1280) begin n_fails++; $display("[TB] FAIL hd_de_run: got %0d want 1280", run); end
    endtask

    initial begin
        reset_n        = 1'b0;
        reset_n_hd     = 1'b0;
        pixel_data_neg = 24'h0;
        pixel_data_hd  = 24'h123456;
        repeat (3) @(negedge pclk);
        test_reset();
        test_timing_counts();
        test_data_path();
        test_reset_mid_frame();
        test_polarity();
        test_default_720p();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Generates raster timing for the HDMI output path and sits directly upstream of the DVI transmitter. It runs horizontal and vertical counters on the pixel clock, asks the frame source for pixels with a request/coordinate interface, and then emits aligned `video_hsync` / `video_vsync` / `video_de` / `video_din` ready for TMDS encoding. Default timing is 1280x720@60 (74.25 MHz pixel clock).

## Interface
- `H_SYNC`, 40: hsync width, pixels
- `H_BACK`, 220: horizontal back porch, pixels
- `H_ACTIVE`, 1280: active pixels per line
- `H_FRONT`, 110: horizontal front porch, pixels
- `V_SYNC`, 5: vsync width, lines
- `V_BACK`, 20: vertical back porch, lines
- `V_ACTIVE`, 720: active lines per frame
- `V_FRONT`, 5: vertical front porch, lines
- `SYNC_POL`, 1'b1: active level of hsync and vsync (1 = positive)
- `pclk`  in  1  pixel clock, the only clock
- `reset_n`  in  1  asynchronous, active-low reset
- `pixel_data`  in  24  RGB888 from the frame source, valid 1 cycle after `data_req`
- `data_req`  out  1  pixel request for coordinate (`pixel_xpos`, `pixel_ypos`)
- `pixel_xpos`  out  11  active column 0..H_ACTIVE-1; 0 when `data_req`=0
- `pixel_ypos`  out  11  active row 0..V_ACTIVE-1; 0 when `data_req`=0
- `video_hsync`  out  1  horizontal sync to the transmitter
- `video_vsync`  out  1  vertical sync to the transmitter
- `video_de`  out  1  data enable to the transmitter
- `video_din`  out  24  RGB888 to the transmitter; 0 when `video_de`=0
- `frame_start`  out  1  one-cycle pulse on the first output cycle of each frame

## Operation
- Horizontal and vertical totals: `H_TOTAL` = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; `V_TOTAL` is the analogous vertical sum.
- `h_cnt` is 12 bits. It runs 0..H_TOTAL-1 and wraps to 0.
- `v_cnt` is 12 bits. It increments only on the `h_cnt` wrap. It runs 0..V_TOTAL-1 and wraps to 0, so both counters wrap on the same cycle at the end of a frame.
- Segment order in both dimensions: sync, back porch, active, front porch.
  - Sync: `h_cnt` < H_SYNC (and the vertical equivalent).
  - Active: H_SYNC+H_BACK ≤ `h_cnt` < H_SYNC+H_BACK+H_ACTIVE (and the vertical equivalent).
- `data_req` is combinational from the counters: horizontal active AND vertical active.
- Coordinates:
  - `pixel_xpos` = `h_cnt` − (H_SYNC+H_BACK)
  - `pixel_ypos` = `v_cnt` − (V_SYNC+V_BACK)
  - Both are truncated to 11 bits and forced to 0 outside the active region.
- Output stage: one register stage.
  - `video_hsync` = registered (horizontal sync ? SYNC_POL : ~SYNC_POL); `video_vsync` is analogous.
  - `video_de` = registered `data_req`.
  - `frame_start` = registered (`h_cnt`==0 && `v_cnt`==0).
  - `video_din` = `video_de` ? `pixel_data` : 24'h0. This mux is combinational, because `pixel_data` is already one cycle behind `data_req`.
- Reset values:
  - Counters 0.
  - `video_hsync` and `video_vsync` at ~SYNC_POL.
  - `video_de`, `frame_start` 0.
  - `video_din` 0.
  - `data_req` 0, and `pixel_xpos`/`pixel_ypos` 0, since counter 0 lies in sync.
- Reset mid-frame: all state clears immediately (asynchronously). The first cycle after release is `h_cnt`=0, `v_cnt`=0. No partial-frame recovery is attempted.
- The source may not stall; `pixel_data` is sampled unconditionally.

## Timing
- Latency from counter state to `video_*` outputs: 1 `pclk`.
- Consumer contract: `pixel_data` for a request at cycle t must be stable at cycle t+1. A registered RAM or FIFO read meets this.
- `video_de` is high for exactly H_ACTIVE consecutive cycles per active line, and for V_ACTIVE lines per frame.
- `video_hsync` leads the first `video_de` of a line by H_SYNC+H_BACK cycles.
- Line period: H_TOTAL cycles. Frame period: H_TOTAL×V_TOTAL cycles.
- `frame_start` coincides with the first cycle of asserted `video_vsync` and `video_hsync`.
- Vsync changes only at line boundaries, on the same output cycle as the hsync leading edge.
- Parameter constraints: each field ≥ 1; totals ≤ 4095; H_ACTIVE and V_ACTIVE ≤ 2047.

## Structure
- Shared package `video_timing_pkg` holds:
  - the default 720p60 timing constants;
  - a 1080p60 timing set;
  - coordinate width 11 and counter width 12.
- No sub-module; the block is a single module containing counters, a decode stage and an output register stage.

## Test plan
Parameters for the small-timing tests: H=2/3/8/2 (H_TOTAL=15), V=1/2/4/1 (V_TOTAL=8), SYNC_POL=1.

- **Reset values:** hold `reset_n`=0 → hsync=vsync=0, de=0, din=0, data_req=0, frame_start=0. Release → first `frame_start` pulse one cycle later.
- **Timing counts (small params):** → hsync high 2 of every 15 cycles; de high 8 consecutive cycles on 4 lines per frame; frame period 120 cycles; vsync high for 15 cycles.
- **Coordinates:**
  - The first `data_req` after `frame_start` has xpos=0, ypos=0.
  - The last request of a frame has xpos=7, ypos=3.
  - Each line's requests run xpos 0..7.
- **Data path:** source returns `pixel_data` = {ypos[7:0], xpos[7:0], 8'hA5} registered one cycle → every `video_de` cycle carries the matching value; `video_din`=0 whenever de=0.
- **Reset mid-frame:** assert `reset_n` on an active pixel at line 2 → outputs return to reset values in the same cycle. After release, the next frame is a full 120 cycles.
- **Polarity and defaults:** SYNC_POL=0 → syncs idle high and pulse low. Default 720p parameters → 1650-cycle lines, 750-line frames, 1280 de cycles per active line.
